conv_multimode: RTL and testbench
=================================

CONV_MULTIMODE -- requirements
Module: conv_multimode

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the X/Y sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning the X/Y address width; Z address is ADDR_WIDTH+1.
REQ-003 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+ADDR_WIDTH, meaning the internal accumulator width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle start request.
REQ-007 signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 mode_i  in  1  0 = FULL convolution, 1 = VALID convolution.
REQ-009 sizeX / sizeY  in  ADDR_WIDTH each  sample counts of X and Y.
REQ-010 memX_addr / memY_addr  out  ADDR_WIDTH each  read addresses.
REQ-011 dataX / dataY  in  DATA_WIDTH each  read data, valid one cycle after the address (synchronous RAM).
REQ-012 dataZ  out  2*DATA_WIDTH  result sample.
REQ-013 memZ_addr  out  ADDR_WIDTH+1  result write address.
REQ-014 writeZ  out  1  one-cycle write strobe for dataZ/memZ_addr.
REQ-015 busy_out  out  1  high from the cycle after accepted start until done_out.
REQ-016 done_out  out  1  one-cycle completion pulse.

Function
REQ-017 SHALL compute Z[n] = sum over k of X[k]*Y[n-k], k from max(0,n-sizeY+1) to min(n,sizeX-1).
REQ-018 FULL mode SHALL produce n = 0 .. sizeX+sizeY-2, written to memZ_addr 0..sizeX+sizeY-2.
REQ-019 VALID mode SHALL produce n = min(sizeX,sizeY)-1 .. max(sizeX,sizeY)-1, written to memZ_addr starting at 0.
REQ-020 sizeX, sizeY, signed_i, mode_i SHALL be registered when start is accepted; later changes have no effect on the running job.
REQ-021 start SHALL be accepted only in IDLE; start while busy is ignored.
REQ-022 FSM states: IDLE, INIT, FETCH, MAC, WRITE, DONE.
REQ-023 IDLE->INIT on start; INIT computes first n and k bounds; FETCH drives the addresses for one product per cycle; MAC accumulates returning data (pipelined, one product per cycle after a 1-cycle fill); WRITE asserts writeZ for exactly one cycle; WRITE->FETCH if outputs remain, else ->DONE; DONE pulses done_out and returns to IDLE.
REQ-024 Per-output latency SHALL be T+2 cycles (T = number of products in that term).
REQ-025 Products SHALL be sign- or zero-extended per signed_i to ACC_WIDTH before accumulation; accumulator clears at the start of each output.
REQ-026 dataZ SHALL saturate the accumulator to the 2*DATA_WIDTH range (signed or unsigned per signed_i).
REQ-027 sizeX = 0 or sizeY = 0 SHALL produce no writeZ, with done_out pulsing 2 cycles after start.
REQ-028 writeZ SHALL never be asserted outside WRITE; memZ_addr SHALL not wrap (max index 2^(ADDR_WIDTH+1)-2).

Reset
REQ-029 While rstn = 0: FSM = IDLE; busy_out, done_out, writeZ = 0; memX_addr, memY_addr, memZ_addr, dataZ, accumulator = 0.
REQ-030 Reset asserted mid-job SHALL abort immediately with no further writes; after release the block waits for a new start.

Structure
REQ-031 State enum, mode encodings (MODE_FULL, MODE_VALID), and saturation helper function SHALL live in shared package conv_pkg.
REQ-032 The multiply-accumulate-saturate datapath SHALL be a sub-module conv_mac (operands, signed flag, clear, enable -> saturated result).

Verification
REQ-033 FULL, unsigned, sizeX=5 X=1..5, sizeY=10 Y all 1 -> 14 writes, Z[0]=1, Z[4]=15, Z[9]=15, Z[13]=5, one done_out.
REQ-034 VALID, unsigned, sizeX=3 X=1,2,3, sizeY=5 Y=1..5 -> 3 writes at addr 0..2: 10, 16, 22.
REQ-035 FULL, signed, sizeX=2 X=-1,2, sizeY=1 Y=3 -> Z=0xFFFD, 0x0006.
REQ-036 Signed saturation: sizeX=sizeY=31, all samples -128 -> centre output Z[30]=0x7FFF.
REQ-037 sizeY=0 -> no writeZ, done_out 2 cycles after start; start pulsed while busy -> ignored, job count unchanged.
REQ-038 rstn low during the 5th output of REQ-033 -> writeZ/busy_out 0 immediately; new start reruns with correct results.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine: FSM state encoding,
// mode encodings and the saturation helper.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_MAC   = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } conv_state_e;

    localparam logic MODE_FULL  = 1'b0;
    localparam logic MODE_VALID = 1'b1;

    // Working width of the saturation helper; callers extend their value to
    // this width and truncate the result back to out_w bits.
    localparam int SAT_W = 64;

    // Clamp val to the out_w-bit signed or unsigned range. In unsigned mode
    // val is treated as non-negative (unsigned accumulation never goes below 0).
    function automatic logic [SAT_W-1:0] sat_to_width(
        input logic [SAT_W-1:0] val,
        input int unsigned      out_w,
        input logic             is_signed
    );
        logic [SAT_W-1:0] hi;
        logic [SAT_W-1:0] lo;
        if (is_signed) begin
            hi = (64'd1 << (out_w - 1)) - 64'd1;
            lo = ~hi;   // -(2^(out_w-1)) in SAT_W-bit two's complement
            if ($signed(val) > $signed(hi)) return hi;
            if ($signed(val) < $signed(lo)) return lo;
            return val;
        end
        hi = (64'd1 << out_w) - 64'd1;
        return (val > hi) ? hi : val;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate-saturate datapath: one product per enabled cycle.
// Latency: product lands in the accumulator on the edge after en_i; result_o is combinational from it.
// Backpressure: none; the controller decides when operands are valid via en_i.
//
// Ports: clk/rstn; a_i/b_i operands; signed_i selects two's-complement;
// clear_i zeroes the accumulator (wins over en_i); en_i adds a_i*b_i;
// result_o is the accumulator saturated to 2*DATA_WIDTH bits.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 21
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    input  logic                    signed_i,
    input  logic                    clear_i,
    input  logic                    en_i,
    output logic [2*DATA_WIDTH-1:0] result_o
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [SAT_W-1:0]     acc_wide;

    always_comb begin
        // Extending operands to the product width first makes the low PW bits
        // of a plain multiply correct for both signed and unsigned operands.
        a_ext    = {{DATA_WIDTH{signed_i & a_i[DATA_WIDTH-1]}}, a_i};
        b_ext    = {{DATA_WIDTH{signed_i & b_i[DATA_WIDTH-1]}}, b_i};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_WIDTH-PW){signed_i & prod[PW-1]}}, prod};

        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end

        acc_wide = {{(SAT_W-ACC_WIDTH){signed_i & acc_q[ACC_WIDTH-1]}}, acc_q};
        result_o = PW'(sat_to_width(acc_wide, PW, signed_i));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_multimode.sv
// 1-D convolution engine (FULL or VALID) over synchronous-read X/Y memories, writing Z.
// Latency: 1 init cycle, then T+2 cycles per output (T products), then 1 done cycle.
// Backpressure: none; Z writes are fire-and-forget, start is ignored while busy.
//
// Ports: clk/rstn; start with signed_i, mode_i, sizeX, sizeY (captured on accept);
// memX_addr/memY_addr with dataX/dataY one cycle later; dataZ/memZ_addr/writeZ
// result write port; busy_out while a job runs; done_out one-cycle completion pulse.
module conv_multimode
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    signed_i,
    input  logic                    mode_i,
    input  logic [ADDR_WIDTH-1:0]   sizeX,
    input  logic [ADDR_WIDTH-1:0]   sizeY,
    output logic [ADDR_WIDTH-1:0]   memX_addr,
    output logic [ADDR_WIDTH-1:0]   memY_addr,
    input  logic [DATA_WIDTH-1:0]   dataX,
    input  logic [DATA_WIDTH-1:0]   dataY,
    output logic [2*DATA_WIDTH-1:0] dataZ,
    output logic [ADDR_WIDTH:0]     memZ_addr,
    output logic                    writeZ,
    output logic                    busy_out,
    output logic                    done_out
);
    localparam int NW = ADDR_WIDTH + 1;

    conv_state_e           state_q,  state_d;
    logic [ADDR_WIDTH-1:0] size_x_q, size_x_d;
    logic [ADDR_WIDTH-1:0] size_y_q, size_y_d;
    logic                  signed_q, signed_d;
    logic                  mode_q,   mode_d;
    logic [NW-1:0]         n_q,      n_d;
    logic [NW-1:0]         n_end_q,  n_end_d;
    logic [NW-1:0]         z_addr_q, z_addr_d;
    logic [ADDR_WIDTH-1:0] k_q,      k_d;
    logic                  issue_q;

    logic [ADDR_WIDTH-1:0] sx_m1;
    logic [ADDR_WIDTH-1:0] k_hi;
    logic [ADDR_WIDTH-1:0] size_min;
    logic [ADDR_WIDTH-1:0] size_max;
    logic [NW-1:0]         n_first;
    logic [NW-1:0]         n_next;

    // Lowest k with n-k < sizeY. The true value is below sizeX, so the
    // subtraction can be done in ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] k_low(
        input logic [NW-1:0]         n,
        input logic [ADDR_WIDTH-1:0] sy
    );
        if (n + NW'(1) > {1'b0, sy}) return n[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1) - sy;
        return '0;
    endfunction

    always_comb begin
        sx_m1    = size_x_q - ADDR_WIDTH'(1);
        k_hi     = (n_q < {1'b0, sx_m1}) ? n_q[ADDR_WIDTH-1:0] : sx_m1;
        size_min = (size_x_q < size_y_q) ? size_x_q : size_y_q;
        size_max = (size_x_q < size_y_q) ? size_y_q : size_x_q;
        n_first  = (mode_q == MODE_VALID) ? {1'b0, size_min - ADDR_WIDTH'(1)} : '0;
        n_next   = n_q + NW'(1);
    end

    always_comb begin
        state_d  = state_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        signed_d = signed_q;
        mode_d   = mode_q;
        n_d      = n_q;
        n_end_d  = n_end_q;
        z_addr_d = z_addr_q;
        k_d      = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_INIT;
                    size_x_d = sizeX;
                    size_y_d = sizeY;
                    signed_d = signed_i;
                    mode_d   = mode_i;
                end
            end
            ST_INIT: begin
                z_addr_d = '0;
                if (size_x_q == '0 || size_y_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                    n_d     = n_first;
                    k_d     = k_low(n_first, size_y_q);
                    n_end_d = (mode_q == MODE_VALID)
                            ? {1'b0, size_max - ADDR_WIDTH'(1)}
                            : {1'b0, size_x_q} + {1'b0, size_y_q} - NW'(2);
                end
            end
            ST_FETCH: begin
                if (k_q == k_hi) begin
                    state_d = ST_MAC;
                end else begin
                    k_d = k_q + ADDR_WIDTH'(1);
                end
            end
            ST_MAC: begin
                // Last product of the term is still in flight from memory.
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (n_q == n_end_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_FETCH;
                    n_d      = n_next;
                    k_d      = k_low(n_next, size_y_q);
                    z_addr_d = z_addr_q + NW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            size_x_q <= '0;
            size_y_q <= '0;
            signed_q <= 1'b0;
            mode_q   <= MODE_FULL;
            n_q      <= '0;
            n_end_q  <= '0;
            z_addr_q <= '0;
            k_q      <= '0;
            issue_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            signed_q <= signed_d;
            mode_q   <= mode_d;
            n_q      <= n_d;
            n_end_q  <= n_end_d;
            z_addr_q <= z_addr_d;
            k_q      <= k_d;
            // Data for an address issued in FETCH returns next cycle.
            issue_q  <= (state_q == ST_FETCH);
        end
    end

    // Clearing in WRITE leaves the finished sum visible on dataZ during the
    // write cycle and zeroes it before the next term's first product arrives.
    conv_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rstn     (rstn),
        .a_i      (dataX),
        .b_i      (dataY),
        .signed_i (signed_q),
        .clear_i  ((state_q == ST_INIT) || (state_q == ST_WRITE)),
        .en_i     (issue_q),
        .result_o (dataZ)
    );

    assign memX_addr = k_q;
    assign memY_addr = n_q[ADDR_WIDTH-1:0] - k_q;
    assign memZ_addr = z_addr_q;
    assign writeZ    = (state_q == ST_WRITE);
    assign busy_out  = (state_q != ST_IDLE);
    assign done_out  = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_multimode.sv
// Scoreboard bench for conv_multimode: directed jobs push expected Z writes,
// a negedge monitor pops and compares each writeZ, and per-job checks cover
// latency, write count, done pulses and reset behaviour.
module tb_conv_multimode;
    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          signed_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [AW-1:0] sizeX = '0;
    logic [AW-1:0] sizeY = '0;
    logic [AW-1:0] memX_addr;
    logic [AW-1:0] memY_addr;
    logic [DW-1:0] dataX;
    logic [DW-1:0] dataY;
    logic [2*DW-1:0] dataZ;
    logic [AW:0]   memZ_addr;
    logic          writeZ;
    logic          busy_out;
    logic          done_out;

    logic [DW-1:0] memX [32];
    logic [DW-1:0] memY [32];

    // Expected writes as {addr, data}.
    logic [AW+2*DW:0] exp_q [$];

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    int t1_z [14] = '{1, 3, 6, 10, 15, 15, 15, 15, 15, 15, 14, 12, 9, 5};

    conv_multimode #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .signed_i  (signed_i),
        .mode_i    (mode_i),
        .sizeX     (sizeX),
        .sizeY     (sizeY),
        .memX_addr (memX_addr),
        .memY_addr (memY_addr),
        .dataX     (dataX),
        .dataY     (dataY),
        .dataZ     (dataZ),
        .memZ_addr (memZ_addr),
        .writeZ    (writeZ),
        .busy_out  (busy_out),
        .done_out  (done_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dataX <= memX[memX_addr];
        dataY <= memY[memY_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every write against the scoreboard head.
    always @(negedge clk) begin
        if (rstn) begin
            if (writeZ) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             memZ_addr, dataZ);
                end else begin
                    logic [AW+2*DW:0] e;
                    e = exp_q.pop_front();
                    check($sformatf("z_addr[%0d]", wr_cnt), 32'(memZ_addr), 32'(e[AW+2*DW:2*DW]));
                    check($sformatf("z_data[%0d]", wr_cnt), 32'(dataZ), 32'(e[2*DW-1:0]));
                end
                wr_cnt++;
            end
            if (done_out) done_cnt++;
        end
    end

    task automatic push(input int addr, input int data);
        exp_q.push_back({addr[AW:0], data[2*DW-1:0]});
    endtask

    task automatic fill(input logic [DW-1:0] xv, input logic [DW-1:0] yv);
        for (int i = 0; i < 32; i++) begin
            memX[i] = xv;
            memY[i] = yv;
        end
    endtask

    task automatic load_t1();
        fill(8'd1, 8'd1);
        for (int i = 0; i < 5; i++) memX[i] = 8'(i + 1);
        for (int i = 0; i < 14; i++) push(i, t1_z[i]);
    endtask

    // Issue one job and wait (bounded) for done_out; poke pulses start and
    // scrambles the job inputs while busy, which must not disturb the job.
    task automatic run_job(input string name, input logic [AW-1:0] sx, input logic [AW-1:0] sy,
                           input logic sg, input logic md, input int exp_lat, input bit poke);
        int lat;
        int d0;
        int nexp;
        d0   = done_cnt;
        nexp = exp_q.size();
        @(posedge clk); #1;
        sizeX = sx; sizeY = sy; signed_i = sg; mode_i = md;
        wr_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check({name, "_busy"}, 32'(busy_out), 1);
        if (poke) begin
            sizeX = 1; sizeY = 1; mode_i = ~md; signed_i = ~sg;
        end
        while (!done_out && lat < 3000) begin
            start = (poke && lat == 6);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        repeat (3) @(posedge clk);
        #1;
        check({name, "_writes"}, 32'(wr_cnt), 32'(nexp));
        check({name, "_pending"}, 32'(exp_q.size()), 0);
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
        check({name, "_idle_busy"}, 32'(busy_out), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        fill(8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_out), 0);
        check("rst_done", 32'(done_out), 0);
        check("rst_writeZ", 32'(writeZ), 0);
        check("rst_xaddr", 32'(memX_addr), 0);
        check("rst_yaddr", 32'(memY_addr), 0);
        check("rst_zaddr", 32'(memZ_addr), 0);
        check("rst_dataZ", 32'(dataZ), 0);
        rstn = 1'b1;

        // FULL unsigned, X=1..5, Y=ten ones; start poked while busy.
        load_t1();
        run_job("full_u", 5'd5, 5'd10, 1'b0, 1'b0, 80, 1'b1);

        // VALID unsigned, X=1,2,3, Y=1..5.
        fill(8'd0, 8'd0);
        for (int i = 0; i < 3; i++) memX[i] = 8'(i + 1);
        for (int i = 0; i < 5; i++) memY[i] = 8'(i + 1);
        push(0, 10); push(1, 16); push(2, 22);
        run_job("valid_u", 5'd3, 5'd5, 1'b0, 1'b1, 17, 1'b0);

        // FULL signed, X=-1,2, Y=3.
        fill(8'd0, 8'd0);
        memX[0] = 8'hFF; memX[1] = 8'h02; memY[0] = 8'h03;
        push(0, 16'hFFFD); push(1, 16'h0006);
        run_job("full_s", 5'd2, 5'd1, 1'b1, 1'b0, 8, 1'b0);

        // Centre term of 31x31: positive, negative and unsigned saturation.
        fill(8'h80, 8'h80);
        push(0, 16'h7FFF);
        run_job("sat_pos", 5'd31, 5'd31, 1'b1, 1'b1, 35, 1'b0);
        fill(8'h80, 8'h7F);
        push(0, 16'h8000);
        run_job("sat_neg", 5'd31, 5'd31, 1'b1, 1'b1, 35, 1'b0);
        fill(8'hFF, 8'hFF);
        push(0, 16'hFFFF);
        run_job("sat_uns", 5'd31, 5'd31, 1'b0, 1'b1, 35, 1'b0);

        // Empty operands: no writes, done two cycles after start.
        run_job("zero_y", 5'd4, 5'd0, 1'b0, 1'b0, 2, 1'b0);
        run_job("zero_x", 5'd0, 5'd7, 1'b1, 1'b1, 2, 1'b0);

        // Reset during the fifth output of the FULL job, then rerun it.
        load_t1();
        @(posedge clk); #1;
        sizeX = 5'd5; sizeY = 5'd10; signed_i = 1'b0; mode_i = 1'b0;
        wr_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (wr_cnt < 4 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("abort_writes_before", 32'(wr_cnt), 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("abort_writeZ", 32'(writeZ), 0);
        check("abort_busy", 32'(busy_out), 0);
        check("abort_zaddr", 32'(memZ_addr), 0);
        check("abort_dataZ", 32'(dataZ), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(busy_out), 0);
        check("abort_no_writes", 32'(wr_cnt), 4);
        load_t1();
        run_job("rerun", 5'd5, 5'd10, 1'b0, 1'b0, 80, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
